// File: rtl/debounce_pkg.sv
// Shared state encoding for the pushbutton debouncer.
package debounce_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for a single asynchronous bit; both stages reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce_pulse.sv
// Pushbutton synchroniser + debounce FSM emitting one pulse per accepted press.
// Define AUTO_REPEAT_EN to add auto-repeat pulses while the button stays held.
module button_debounce_pulse
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 8
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse,
  output logic btn_level
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic btn_sync;
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic pulse_d, level_d;

  sync_2ff u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (btn_sync)
  );

`ifdef AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT   = RPT_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY);

  logic [RPT_W-1:0] rpt_cnt, rpt_d;

  always_ff @(posedge clk) begin
    if (reset) rpt_cnt <= '0;
    else       rpt_cnt <= rpt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pulse     <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      pulse     <= pulse_d;
      btn_level <= level_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pulse_d = 1'b0;
    level_d = btn_level;
`ifdef AUTO_REPEAT_EN
    rpt_d   = rpt_cnt;
`endif
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_d = CONFIRM_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      CONFIRM_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
`ifdef AUTO_REPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d = CONFIRM_RELEASE;
          cnt_d   = CNT_ONE;
        end
`ifdef AUTO_REPEAT_EN
        // Counter folds back to REPEAT_DELAY so later repeats recur every REPEAT_PERIOD.
        else if (rpt_cnt == RPT_FIRST || rpt_cnt == RPT_NEXT) begin
          pulse_d = 1'b1;
          rpt_d   = RPT_RELOAD;
        end else begin
          rpt_d = rpt_cnt + RPT_W'(1);
        end
`endif
      end
      CONFIRM_RELEASE: begin
        if (btn_sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
`ifdef AUTO_REPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
